// File: rtl/fp_pkg.sv
// Shared floating-point definitions: FSM state encoding, rounding-mode codes
// and the rounding-increment decision used by every FP core.
package fp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MULT  = 3'd1,
    ST_NORM  = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } fp_state_e;

  // Rounding-mode codes shared with the rest of the FP family.
  localparam logic [2:0] RND_IEEE_NEAR = 3'd0;
  localparam logic [2:0] RND_IEEE_ZERO = 3'd1;
  localparam logic [2:0] RND_IEEE_PINF = 3'd2;
  localparam logic [2:0] RND_IEEE_NINF = 3'd3;
  localparam logic [2:0] RND_NEAR_UP   = 3'd4;
  localparam logic [2:0] RND_AWAY_ZERO = 3'd5;

  localparam logic [4:0] MULT_LAST = 5'd23;

  function automatic logic round_inc(input logic [2:0] rnd, input logic sign,
                                     input logic lsb, input logic g, input logic s);
    logic inc;
    case (rnd)
      RND_IEEE_NEAR: inc = g & (s | lsb);
      RND_NEAR_UP:   inc = g;
      RND_IEEE_ZERO: inc = 1'b0;
      RND_IEEE_PINF: inc = ~sign & (g | s);
      RND_IEEE_NINF: inc = sign & (g | s);
      RND_AWAY_ZERO: inc = g | s;
      default:       inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational rounding stage: applies the mode-dependent increment,
// renormalises on carry-out and derives the raw range/inexact status.
module fp_round
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp_in,
  input  logic [23:0]       sig_in,
  input  logic              g,
  input  logic              s,
  input  logic [2:0]        rnd,
  output logic [31:0]       z,
  output logic              overflow,
  output logic              underflow,
  output logic              inexact
);

  logic              inc_s;
  logic [24:0]       sum_s;
  logic [22:0]       mant_s;
  logic signed [9:0] exp_s;

  // Increment, carry renormalisation and flag derivation
  always_comb begin
    inc_s = round_inc(rnd, sign, sig_in[0], g, s);
    sum_s = {1'b0, sig_in} + {24'd0, inc_s};
    if (sum_s[24]) begin
      mant_s = sum_s[23:1];
      exp_s  = exp_in + 10'sd1;
    end else begin
      mant_s = sum_s[22:0];
      exp_s  = exp_in;
    end
    overflow  = (exp_s >= 10'sd255);
    underflow = (exp_s <= 10'sd0);
    inexact   = g | s;
    z         = {sign, exp_s[7:0], mant_s};
  end

endmodule

// File: rtl/fp_mult_core.sv
// Sequential binary32 multiplier core: radix-2 shift-add significand product,
// single-step normalisation and shared rounding; results held until consumed.
module fp_mult_core
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  rnd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z_calc,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  fp_state_e         state_r;
  fp_state_e         state_nxt_s;
  logic [4:0]        cnt_r;
  logic [47:0]       prod_r;
  logic [23:0]       mcand_r;
  logic signed [9:0] exp_r;
  logic              sign_r;
  logic [2:0]        rnd_r;
  logic [23:0]       sig_r;
  logic              g_r;
  logic              s_r;
  logic [24:0]       add_s;
  logic [31:0]       rnd_z_s;
  logic              rnd_ovf_s;
  logic              rnd_unf_s;
  logic              rnd_inx_s;
  logic [31:0]       z_calc_r;
  logic              ovf_r;
  logic              unf_r;
  logic              inx_r;
  logic              in_ready_r;
  logic              out_valid_r;

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_nxt_s = ST_MULT;
        else          state_nxt_s = ST_IDLE;
      end
      ST_MULT: begin
        if (cnt_r == MULT_LAST) state_nxt_s = ST_NORM;
        else                    state_nxt_s = ST_MULT;
      end
      ST_NORM:  state_nxt_s = ST_ROUND;
      ST_ROUND: state_nxt_s = ST_DONE;
      ST_DONE: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with handshake outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
    end
  end

  // Partial-product accumulate: upper half plus multiplicand when the LSB is set
  always_comb begin
    if (prod_r[0]) add_s = {1'b0, prod_r[47:24]} + {1'b0, mcand_r};
    else           add_s = {1'b0, prod_r[47:24]};
  end

  fp_round u_round (
    .sign      (sign_r),
    .exp_in    (exp_r),
    .sig_in    (sig_r),
    .g         (g_r),
    .s         (s_r),
    .rnd       (rnd_r),
    .z         (rnd_z_s),
    .overflow  (rnd_ovf_s),
    .underflow (rnd_unf_s),
    .inexact   (rnd_inx_s)
  );

  // Datapath: operand capture, shift-add, normalisation and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= 5'd0;
      prod_r   <= 48'd0;
      mcand_r  <= 24'd0;
      exp_r    <= 10'sd0;
      sign_r   <= 1'b0;
      rnd_r    <= 3'd0;
      sig_r    <= 24'd0;
      g_r      <= 1'b0;
      s_r      <= 1'b0;
      z_calc_r <= 32'd0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      inx_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            mcand_r <= {|a[30:23], a[22:0]};
            prod_r  <= {24'd0, |b[30:23], b[22:0]};
            exp_r   <= $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
            sign_r  <= a[31] ^ b[31];
            rnd_r   <= rnd;
            cnt_r   <= 5'd0;
          end
        end
        ST_MULT: begin
          prod_r <= {add_s, prod_r[23:1]};
          cnt_r  <= (cnt_r == MULT_LAST) ? 5'd0 : cnt_r + 5'd1;
        end
        ST_NORM: begin
          // Product lies in [1,4); a set top bit means one right shift
          if (prod_r[47]) begin
            sig_r <= prod_r[47:24];
            g_r   <= prod_r[23];
            s_r   <= |prod_r[22:0];
            exp_r <= exp_r + 10'sd1;
          end else begin
            sig_r <= prod_r[46:23];
            g_r   <= prod_r[22];
            s_r   <= |prod_r[21:0];
          end
        end
        ST_ROUND: begin
          z_calc_r <= rnd_z_s;
          ovf_r    <= rnd_ovf_s;
          unf_r    <= rnd_unf_s;
          inx_r    <= rnd_inx_s;
        end
        ST_DONE: begin
          z_calc_r <= z_calc_r;
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign z_calc    = z_calc_r;
  assign overflow  = ovf_r;
  assign underflow = unf_r;
  assign inexact   = inx_r;

endmodule

// File: doc/fp_mult_core.md
FP_MULT_CORE -- requirements
Module: fp_mult_core

Interface
REQ-001 The block SHALL have no parameters; field widths SHALL be fixed to IEEE-754 binary32.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand set valid.
REQ-006 in_ready  output  1  block idle and able to accept operands.
REQ-007 a, b  input  32  binary32 operands, sampled on acceptance.
REQ-008 rnd  input  3  rounding mode from defs.svh, sampled on acceptance.
REQ-009 out_valid  output  1  result valid, held until accepted.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 z_calc  output  32  raw rounded product for the exception unit.
REQ-012 overflow, underflow, inexact  output  1 each  raw datapath status for the exception unit.

Function
REQ-013 Acceptance SHALL occur on a clk edge with in_valid && in_ready; a, b and rnd SHALL be registered at that edge and SHALL be ignored at all other times.
REQ-014 FSM states SHALL be IDLE, MULT, NORM, ROUND, DONE: IDLE->MULT on acceptance; MULT->NORM after exactly 24 cycles; NORM->ROUND; ROUND->DONE; DONE->IDLE on out_ready.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 out_valid SHALL rise 26 cycles after the accepting edge; z_calc and flags SHALL stay stable while out_valid && !out_ready.
REQ-017 MULT SHALL be a radix-2 shift-add over the 24-bit significands, one multiplier bit per cycle, with a 5-bit counter.
REQ-018 Implicit bit SHALL be 1 when exp != 0, else 0; sign = a[31]^b[31].
REQ-019 Exponent SHALL be a 10-bit signed sum ea+eb-127.
REQ-020 NORM: if P[47]=1, shift right one and add 1 to the exponent; G = first discarded bit; S = OR of all remaining discarded bits.
REQ-021 ROUND increment: IEEE_near G&&(S||lsb); near_up G; IEEE_zero never; IEEE_pinf !sign&&(G||S); IEEE_ninf sign&&(G||S); away_zero G||S.
REQ-022 Significand carry-out after rounding SHALL renormalise: shift right and add 1 to the exponent.
REQ-023 Flag rules: overflow = final exp >= 255; underflow = final exp <= 0; inexact = G||S. z_calc = {sign, exp[7:0], mantissa[22:0]}, truncated when overflow or underflow.
REQ-024 Special operands (zero, denormal, inf, NaN) SHALL pass through the same datapath without special-casing; the downstream exception unit overrides those results.

Reset
REQ-025 While rst_n = 0: state IDLE, in_ready = 1, out_valid = 0, z_calc = 0, overflow = underflow = inexact = 0, counter = 0.
REQ-026 Reset assertion in any state SHALL abort the operation in progress immediately; no result for it SHALL ever appear.

Structure
REQ-027 The rounding-mode constants SHALL come from the shared defs.svh.
REQ-028 The FSM state enum SHALL live in the shared package fp_pkg.
REQ-029 The ROUND logic (REQ-021, REQ-022) SHALL be a combinational sub-module fp_round, reusable by later adder and divider cores.

Verification
REQ-030 a=0x3FC00000, b=0x40000000, IEEE_near -> out_valid at cycle 26, z_calc=0x40400000, all flags 0.
REQ-031 a=b=0x3F800001: IEEE_near -> z_calc=0x3F800002, inexact=1; IEEE_pinf -> z_calc=0x3F800003, inexact=1.
REQ-032 Range limits: a=b=0x7F000000 -> overflow=1, underflow=0; a=b=0x00800000 -> underflow=1, overflow=0.
REQ-033 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0; out_ready=1 -> IDLE next cycle and a new operand set is accepted.
REQ-034 Reset mid-operation: assert rst_n=0 at cycle 12 of MULT -> in_ready=1 and out_valid=0 at once; the next operation completes correctly with the REQ-030 values.
